// File: rtl/upshifter_if.sv
// upshifter_if: sample/result bundle for the +fs/8 up-shifter.
// master drives baseband samples and controls; slave (the shifter) returns IF results.
interface upshifter_if;
    logic signed [11:0] i_in;
    logic signed [11:0] q_in;
    logic               in_valid;
    logic               bypass;
    logic               phase_sync;
    logic signed [11:0] i_out;
    logic signed [11:0] q_out;
    logic               out_valid;

    modport master (
        output i_in, q_in, in_valid, bypass, phase_sync,
        input  i_out, q_out, out_valid
    );

    modport slave (
        input  i_in, q_in, in_valid, bypass, phase_sync,
        output i_out, q_out, out_valid
    );
endinterface

// File: rtl/upshifter.sv
// upshifter: rotates a baseband I/Q stream by +fs/8 per accepted sample (BB -> IF).
// Two-stage pipeline: stage 1 holds the four coefficient products, stage 2 the
// shifted (and optionally limited) sums.
// Build option: define UPSHIFTER_SAT_EN to saturate each rail to [-2048, 2047];
// without it the result wraps to the low 12 bits.
module upshifter #(
    parameter logic [2:0] PHASE_INIT = 3'd0
) (
    input logic        clk,
    input logic        rst_neg,
    upshifter_if.slave bus
);

    logic               accept;
    logic [2:0]         phase;
    logic [2:0]         phase_next;
    logic [2:0]         phase_use;

    logic signed [12:0] sin_c;
    logic signed [12:0] cos_c;

    logic signed [24:0] ic_next;
    logic signed [24:0] qs_next;
    logic signed [24:0] is_next;
    logic signed [24:0] qc_next;

    logic signed [24:0] p_ic;
    logic signed [24:0] p_qs;
    logic signed [24:0] p_is;
    logic signed [24:0] p_qc;
    logic               s1_valid;
    logic               s1_bypass;

    logic signed [25:0] sum_i;
    logic signed [25:0] sum_q;
    logic signed [11:0] res_i;
    logic signed [11:0] res_q;

    logic signed [11:0] i_out_r;
    logic signed [11:0] q_out_r;
    logic               out_valid_r;

    // Phase selection: a synced rotating sample uses index 0 and leaves the counter at 1.
    always_comb begin
        accept     = bus.in_valid && !bus.bypass;
        phase_use  = (bus.phase_sync && accept) ? 3'd0 : phase;
        phase_next = phase;
        if (accept) begin
            phase_next = phase_use + 3'd1;
        end else if (bus.phase_sync) begin
            phase_next = 3'd0;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            phase <= PHASE_INIT;
        end else begin
            phase <= phase_next;
        end
    end

    // Coefficient table (sin, cos) scaled by 4095.
    always_comb begin
        sin_c = 13'sd0;
        cos_c = 13'sd0;
        unique case (phase_use)
            3'd0: begin sin_c = 13'sd0;     cos_c = 13'sd4095;  end
            3'd1: begin sin_c = 13'sd2896;  cos_c = 13'sd2896;  end
            3'd2: begin sin_c = 13'sd4095;  cos_c = 13'sd0;     end
            3'd3: begin sin_c = 13'sd2896;  cos_c = -13'sd2896; end
            3'd4: begin sin_c = 13'sd0;     cos_c = -13'sd4095; end
            3'd5: begin sin_c = -13'sd2896; cos_c = -13'sd2896; end
            3'd6: begin sin_c = -13'sd4095; cos_c = 13'sd0;     end
            3'd7: begin sin_c = -13'sd2896; cos_c = 13'sd2896;  end
            default: begin sin_c = 13'sd0;  cos_c = 13'sd0;     end
        endcase
    end

    // Stage-1 operands; a bypassed sample parks the raw I/Q in the ic/qc slots.
    always_comb begin
        ic_next = 25'(bus.i_in) * 25'(cos_c);
        qs_next = 25'(bus.q_in) * 25'(sin_c);
        is_next = 25'(bus.i_in) * 25'(sin_c);
        qc_next = 25'(bus.q_in) * 25'(cos_c);
        if (bus.bypass) begin
            ic_next = 25'(bus.i_in);
            qs_next = 25'sd0;
            is_next = 25'sd0;
            qc_next = 25'(bus.q_in);
        end
    end

    // Stage 1: product registers with valid and bypass tags.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            p_ic      <= 25'sd0;
            p_qs      <= 25'sd0;
            p_is      <= 25'sd0;
            p_qc      <= 25'sd0;
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                p_ic      <= ic_next;
                p_qs      <= qs_next;
                p_is      <= is_next;
                p_qc      <= qc_next;
                s1_bypass <= bus.bypass;
            end
        end
    end

    // Sum, floor shift by 12, then limit (or wrap) each rail; bypass takes the raw sample.
    always_comb begin
        logic signed [13:0] sh_i;
        logic signed [13:0] sh_q;
        sum_i = 26'(p_ic) - 26'(p_qs);
        sum_q = 26'(p_is) + 26'(p_qc);
        sh_i  = 14'(sum_i >>> 12);
        sh_q  = 14'(sum_q >>> 12);
`ifdef UPSHIFTER_SAT_EN
        if (sh_i > 14'sd2047) begin
            res_i = 12'sd2047;
        end else if (sh_i < -14'sd2048) begin
            res_i = -12'sd2048;
        end else begin
            res_i = 12'(sh_i);
        end
        if (sh_q > 14'sd2047) begin
            res_q = 12'sd2047;
        end else if (sh_q < -14'sd2048) begin
            res_q = -12'sd2048;
        end else begin
            res_q = 12'(sh_q);
        end
`else
        res_i = 12'(sh_i);
        res_q = 12'(sh_q);
`endif
        if (s1_bypass) begin
            res_i = 12'(p_ic);
            res_q = 12'(p_qc);
        end
    end

    // Stage 2: output registers, updated only when a result arrives.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            i_out_r     <= 12'sd0;
            q_out_r     <= 12'sd0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                i_out_r <= res_i;
                q_out_r <= res_q;
            end
        end
    end

    assign bus.i_out     = i_out_r;
    assign bus.q_out     = q_out_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_upshifter.sv
// tb_upshifter: scoreboard bench for the +fs/8 up-shifter.
module tb_upshifter;

    logic clk = 1'b0;
    logic rst_neg = 1'b0;
    upshifter_if bus ();

    upshifter #(.PHASE_INIT(3'd0)) dut (
        .clk     (clk),
        .rst_neg (rst_neg),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int due;
    } exp_t;

    localparam int SIN_T[8] = '{0, 2896, 4095, 2896, 0, -2896, -4095, -2896};
    localparam int COS_T[8] = '{4095, 2896, 0, -2896, -4095, -2896, 0, 2896};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [2:0]  mphase = 3'd0;
    logic [11:0] last_i = '0;
    logic [11:0] last_q = '0;
    string       cur_tag = "init";

    always @(posedge clk) cyc++;

    // Independent rotation model: floor shift, then wrap or clamp.
    function automatic int model(input int i, input int q, input logic [2:0] p, input bit qr);
        longint s;
        if (qr) s = longint'(i) * SIN_T[p] + longint'(q) * COS_T[p];
        else    s = longint'(i) * COS_T[p] - longint'(q) * SIN_T[p];
        s = s >>> 12;
`ifdef UPSHIFTER_SAT_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
`else
        s = s & 64'sd4095;
        if (s >= 2048) s = s - 4096;
`endif
        return int'(s);
    endfunction

    // Output monitor: pops the scoreboard on out_valid, checks hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_neg !== 1'b1) begin
            last_i = '0;
            last_q = '0;
        end else if (bus.out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s unexpected_out_valid cyc=%0d got i=%0d q=%0d",
                         cur_tag, cyc, $signed(bus.i_out), $signed(bus.q_out));
            end else begin
                e = sb.pop_front();
                if (bus.i_out !== 12'(e.i) || bus.q_out !== 12'(e.q) || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s result cyc=%0d got i=%0d q=%0d required i=%0d q=%0d at cyc=%0d",
                             cur_tag, cyc, $signed(bus.i_out), $signed(bus.q_out), e.i, e.q, e.due);
                end
            end
            last_i = bus.i_out;
            last_q = bus.q_out;
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s missing_out_valid cyc=%0d required i=%0d q=%0d",
                         cur_tag, cyc, e.i, e.q);
            end
            checks++;
            if (bus.i_out !== last_i || bus.q_out !== last_q || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s hold cyc=%0d got i=%0d q=%0d v=%b required i=%0d q=%0d v=0",
                         cur_tag, cyc, $signed(bus.i_out), $signed(bus.q_out), bus.out_valid,
                         $signed(last_i), $signed(last_q));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid   = 1'b0;
            bus.bypass     = 1'b0;
            bus.phase_sync = 1'b0;
        end
    endtask

    // Drive one cycle; push the expected result (given, or from the model) for valid samples.
    task automatic send(input int i, input int q, input bit v, input bit byp, input bit sync,
                        input bit given, input int ei, input int eq);
        logic [2:0] p;
        exp_t       e;
        @(posedge clk);
        #1;
        bus.i_in       = 12'(i);
        bus.q_in       = 12'(q);
        bus.in_valid   = v;
        bus.bypass     = byp;
        bus.phase_sync = sync;
        p = (sync && v && !byp) ? 3'd0 : mphase;
        if (v) begin
            e.due = cyc + 2;
            if (byp) begin
                e.i = i;
                e.q = q;
            end else if (given) begin
                e.i = ei;
                e.q = eq;
            end else begin
                e.i = model(i, q, p, 1'b0);
                e.q = model(i, q, p, 1'b1);
            end
            sb.push_back(e);
        end
        if (v && !byp) mphase = p + 3'd1;
        else if (sync) mphase = 3'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            idle(1);
            n++;
        end
        idle(2);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout got pending=%0d required pending=0", cur_tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.bypass     = 1'b0;
        bus.phase_sync = 1'b0;
        rst_neg        = 1'b0;
        #1;
        checks++;
        if (bus.i_out !== 12'd0 || bus.q_out !== 12'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s async_clear got i=%0d q=%0d v=%b required 0 0 0", cur_tag,
                     $signed(bus.i_out), $signed(bus.q_out), bus.out_valid);
        end
        sb.delete();
        mphase = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_neg = 1'b1;
    endtask

    task automatic test_reset();
        cur_tag = "reset";
        rst_neg = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            bus.i_in       = 12'($urandom);
            bus.q_in       = 12'($urandom);
            bus.in_valid   = 1'($urandom);
            bus.bypass     = 1'($urandom);
            bus.phase_sync = 1'($urandom);
            #1;
            checks++;
            if (bus.i_out !== 12'd0 || bus.q_out !== 12'd0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got i=%0d q=%0d v=%b required 0 0 0", k,
                         $signed(bus.i_out), $signed(bus.q_out), bus.out_valid);
            end
        end
        idle(1);
        rst_neg = 1'b1;
        mphase  = 3'd0;
        idle(2);
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        drain();
    endtask

    task automatic test_rotation();
        int ei[8] = '{999, 707, 0, -708, -1000, -708, 0, 707};
        int eq[8] = '{0, 707, 999, 707, 0, -708, -1000, -708};
        cur_tag = "rotation";
        do_reset();
        for (int k = 0; k < 8; k++) send(1000, 0, 1, 0, 0, 1, ei[k], eq[k]);
        drain();
    endtask

    task automatic test_gapped();
        int ei[8] = '{999, 707, 0, -708, -1000, -708, 0, 707};
        int eq[8] = '{0, 707, 999, 707, 0, -708, -1000, -708};
        cur_tag = "gapped";
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send(1000, 0, 1, 0, 0, 1, ei[k], eq[k]);
            send(1000, 0, 0, 0, 0, 0, 0, 0);
        end
        drain();
    endtask

    task automatic test_corner();
        cur_tag = "corner";
        do_reset();
        send(1000, 0, 1, 0, 0, 1, 999, 0);
`ifdef UPSHIFTER_SAT_EN
        send(-2048, 2047, 1, 0, 0, 1, -2048, -1);
`else
        send(-2048, 2047, 1, 0, 0, 1, 1200, -1);
`endif
        send(2047, 2047, 1, 0, 0, 0, 0, 0);
        send(-2048, -2048, 1, 0, 0, 0, 0, 0);
        drain();
    endtask

    task automatic test_bypass();
        cur_tag = "bypass";
        do_reset();
        send(123, -45, 1, 1, 0, 0, 0, 0);
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        send(-7, 9, 1, 1, 0, 0, 0, 0);
        send(1000, 0, 1, 0, 0, 1, 707, 707);
        drain();
    endtask

    task automatic test_sync();
        cur_tag = "sync";
        do_reset();
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        send(1000, 0, 1, 0, 0, 1, 707, 707);
        send(1000, 0, 1, 0, 0, 1, 0, 999);
        send(1000, 0, 1, 0, 1, 1, 999, 0);
        send(1000, 0, 1, 0, 0, 1, 707, 707);
        send(0, 0, 0, 0, 1, 0, 0, 0);
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        drain();
    endtask

    task automatic test_midreset();
        cur_tag = "midreset";
        do_reset();
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        send(1000, 0, 1, 0, 0, 1, 707, 707);
        do_reset();
        idle(3);
        send(1000, 0, 1, 0, 0, 1, 999, 0);
        drain();
    endtask

    task automatic test_back_to_back();
        cur_tag = "back_to_back";
        do_reset();
        for (int k = 0; k < 60; k++) begin
            send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
                 $urandom_range(3) != 0, $urandom_range(4) == 0, $urandom_range(9) == 0,
                 0, 0, 0);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_in       = '0;
        bus.q_in       = '0;
        bus.in_valid   = 1'b0;
        bus.bypass     = 1'b0;
        bus.phase_sync = 1'b0;
        test_reset();
        test_rotation();
        test_gapped();
        test_corner();
        test_bypass();
        test_sync();
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
